// File: rtl/fb_pkg.sv
// Shared constants, types and helpers for the frame-buffer port A scheduler.
package fb_pkg;

    localparam int unsigned FB_W      = 256;
    localparam int unsigned FB_H      = 240;
    localparam int unsigned PIX_W     = 3;
    localparam int unsigned ADDR_W    = 17;
    localparam int unsigned FB_PIXELS = FB_H * 256;

    typedef logic [PIX_W-1:0]  pixel_t;
    typedef logic [7:0]        coord_t;
    typedef logic [ADDR_W-1:0] fb_addr_t;

    typedef enum logic [1:0] {IDLE, CLEAR, DONE} sched_state_t;

    // Linear address y*256 + x; upper (page) bits left at zero.
    function automatic fb_addr_t fb_pack_addr(input coord_t x, input coord_t y);
        return {{(ADDR_W-16){1'b0}}, y, x};
    endfunction

    function automatic logic fb_y_in_range(input coord_t y);
        return y < coord_t'(FB_H);
    endfunction

endpackage

// File: rtl/fb_clear_seq.sv
// Screen-clear address counter with terminal-count flag on the last visible pixel.
module fb_clear_seq
    import fb_pkg::*;
(
    input  logic     clock,
    input  logic     reset_n,
    input  logic     start,
    input  logic     enable,
    output fb_addr_t addr,
    output logic     last
);

    localparam logic [15:0] LAST_IDX = 16'(FB_PIXELS - 1);

    logic [15:0] count_q;

    // Counter restarts on start, advances once per enabled cycle, wraps after the last pixel.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else if (start) begin
            count_q <= '0;
        end else if (enable) begin
            count_q <= last ? 16'd0 : count_q + 16'd1;
        end
    end

    assign last = (count_q == LAST_IDX);
    assign addr = fb_addr_t'(count_q);

endmodule

// File: rtl/fb_port_a_sched.sv
// Port A scheduler: round-robin plot/read arbitration plus an exclusive screen-clear
// sequencer, driving a 1-cycle-latency frame-buffer port.
// Optional feature: define FB_DOUBLE_BUFFER_EN for front/back page swapping on vblank.
module fb_port_a_sched
    import fb_pkg::*;
(
    input  logic     clock,
    input  logic     reset_n,
    input  logic     wr_valid,
    output logic     wr_ready,
    input  coord_t   wr_x,
    input  coord_t   wr_y,
    input  pixel_t   wr_pix,
    input  logic     rd_valid_in,
    output logic     rd_ready,
    input  coord_t   rd_x,
    input  coord_t   rd_y,
    output logic     rd_valid,
    output pixel_t   rd_data,
    input  logic     clear_start,
    input  pixel_t   clear_pix,
    output logic     busy,
    output logic     clear_done,
`ifdef FB_DOUBLE_BUFFER_EN
    input  logic     swap_req,
    input  logic     vblank,
    output logic     disp_page,
`endif
    output logic     mem_we,
    output fb_addr_t mem_addr,
    output pixel_t   mem_din,
    input  pixel_t   mem_dout
);

    sched_state_t state_q, state_d;
    logic         last_rd_q;      // 1 when the most recent grant went to the reader
    pixel_t       clr_pix_q;
    logic         clr_start, clr_en, clr_last;
    fb_addr_t     clr_addr;
    fb_addr_t     page_mask;
    logic         arb_open;

    logic         mem_we_q, mem_we_d;
    fb_addr_t     mem_addr_q, mem_addr_d;
    pixel_t       mem_din_q, mem_din_d;

    logic         rd_p0_q, rd_p0_oob_q, rd_p1_q, rd_p1_oob_q;
    logic         rd_valid_q;
    pixel_t       rd_data_q;

    fb_clear_seq u_clear_seq (
        .clock   (clock),
        .reset_n (reset_n),
        .start   (clr_start),
        .enable  (clr_en),
        .addr    (clr_addr),
        .last    (clr_last)
    );

`ifdef FB_DOUBLE_BUFFER_EN
    logic disp_page_q, swap_pend_q, swap_now;

    assign swap_now = vblank && swap_pend_q && (state_q != CLEAR);

    // Sticky swap request; page flips on the first vblank clock outside a clear.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            disp_page_q <= 1'b0;
            swap_pend_q <= 1'b0;
        end else begin
            swap_pend_q <= swap_req | (swap_pend_q & ~swap_now);
            if (swap_now) begin
                disp_page_q <= ~disp_page_q;
            end
        end
    end

    assign disp_page = disp_page_q;
    assign page_mask = {~disp_page_q, {(ADDR_W-1){1'b0}}};
`else
    assign page_mask = '0;
`endif

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and clear counter control.
    always_comb begin
        state_d   = state_q;
        clr_start = 1'b0;
        clr_en    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (clear_start) begin
                    state_d   = CLEAR;
                    clr_start = 1'b1;
                end
            end
            CLEAR: begin
                clr_en = 1'b1;
                if (clr_last) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Round-robin grant; clear_start pre-empts both requesters in the same cycle.
    always_comb begin
        arb_open = reset_n && (state_q == IDLE) && !clear_start;
        wr_ready = arb_open && wr_valid && (!rd_valid_in || last_rd_q);
        rd_ready = arb_open && rd_valid_in && (!wr_valid || !last_rd_q);
    end

    // Next memory command: clear write, plot write, read, or hold with we low.
    always_comb begin
        mem_we_d   = 1'b0;
        mem_addr_d = mem_addr_q;
        mem_din_d  = mem_din_q;
        if (state_q == CLEAR) begin
            mem_we_d   = 1'b1;
            mem_addr_d = clr_addr | page_mask;
            mem_din_d  = clr_pix_q;
        end else if (wr_ready) begin
            mem_we_d   = fb_y_in_range(wr_y);
            mem_addr_d = fb_pack_addr(wr_x, wr_y) | page_mask;
            mem_din_d  = wr_pix;
        end else if (rd_ready) begin
            mem_addr_d = fb_pack_addr(rd_x, rd_y) | page_mask;
        end
    end

    // Registered memory command, arbitration pointer and clear colour.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_din_q  <= '0;
            last_rd_q  <= 1'b1;
            clr_pix_q  <= '0;
        end else begin
            mem_we_q   <= mem_we_d;
            mem_addr_q <= mem_addr_d;
            mem_din_q  <= mem_din_d;
            if (wr_ready) begin
                last_rd_q <= 1'b0;
            end else if (rd_ready) begin
                last_rd_q <= 1'b1;
            end
            if (clr_start) begin
                clr_pix_q <= clear_pix;
            end
        end
    end

    // Read return pipeline: accept, memory sample, data capture; out-of-range reads return 0.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_p0_q     <= 1'b0;
            rd_p0_oob_q <= 1'b0;
            rd_p1_q     <= 1'b0;
            rd_p1_oob_q <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
        end else begin
            rd_p0_q     <= rd_ready;
            rd_p0_oob_q <= rd_ready && !fb_y_in_range(rd_y);
            rd_p1_q     <= rd_p0_q;
            rd_p1_oob_q <= rd_p0_oob_q;
            rd_valid_q  <= rd_p1_q;
            if (rd_p1_q) begin
                rd_data_q <= rd_p1_oob_q ? '0 : mem_dout;
            end
        end
    end

    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_din    = mem_din_q;
    assign rd_valid   = rd_valid_q;
    assign rd_data    = rd_data_q;
    assign busy       = (state_q == CLEAR);
    assign clear_done = (state_q == DONE);

endmodule

// File: doc/fb_port_a_sched.md
Name: fb_port_a_sched

Overview:
- Scheduler and sequencer for port A of the 256x240, 3-bit-pixel dual-port frame buffer. Port B is owned by VGA scanout and is not touched here.
- Shares port A between a pixel-plot write requester and a pixel-read requester using round-robin arbitration.
- Contains a screen-clear sequencer that takes port A exclusively and fills every visible pixel with one colour.
- Sits between the drawing logic and the frame-buffer memory instance.

Parameters:
- FB_W, 256, visible width in pixels; x is 8 bits.
- FB_H, 240, visible height in lines; y is 8 bits.
- PIX_W, 3, pixel width in bits.
- ADDR_W, 17, memory address width.

Ports:
- clock  in  1  system clock; all logic is on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- wr_valid  in  1  plot request valid.
- wr_ready  out  1  plot request accepted this cycle.
- wr_x  in  8  plot column.
- wr_y  in  8  plot line.
- wr_pix  in  PIX_W  plot colour.
- rd_valid_in  in  1  read request valid.
- rd_ready  out  1  read request accepted this cycle.
- rd_x  in  8  read column.
- rd_y  in  8  read line.
- rd_valid  out  1  read data valid, one-cycle pulse.
- rd_data  out  PIX_W  returned pixel.
- clear_start  in  1  clear trigger pulse.
- clear_pix  in  PIX_W  clear colour; sampled on the cycle clear_start is accepted.
- busy  out  1  clear in progress.
- clear_done  out  1  one-cycle pulse when the clear completes.
- mem_we  out  1  to memory WE_A.
- mem_addr  out  ADDR_W  to memory addr_A.
- mem_din  out  PIX_W  to memory dataIn_A.
- mem_dout  in  PIX_W  from memory dataOut_A; memory read latency is 1 clock.

Behaviour:
- Reset: clock is single; reset_n is asynchronous and active-low. While reset_n=0, all outputs are 0, the FSM is in IDLE, the clear counter is 0, and the round-robin pointer points to read, so plot wins the first tie.
- Address mapping: addr = {ADDR_W-16 zero bits, y[7:0], x[7:0]}, i.e. y*256 + x.
- FSM states are IDLE, CLEAR and DONE.
  - IDLE to CLEAR: clear_start=1. Latch clear_pix and set counter to 0.
  - CLEAR to DONE: after the write to address FB_H*256-1, which is 61439.
  - DONE to IDLE: unconditional after one cycle. clear_done=1 only during DONE.
- Handshake:
  - A request transfers on the edge where valid=1 and ready=1.
  - wr_ready and rd_ready are combinational. Both are 0 outside IDLE, and both are 0 in an IDLE cycle where clear_start=1, because clear has top priority.
- Arbitration in IDLE:
  - Only one requester valid: it is granted.
  - Both valid: the requester not granted last time wins, and the pointer updates on each grant.
  - At most one grant per cycle.
- Memory command:
  - mem_we, mem_addr and mem_din are registered and update on the edge where the grant is accepted.
  - When there is no grant, mem_we=0 and mem_addr/mem_din hold their values.
  - A read grant drives mem_we=0 with the read address.
- Read latency:
  - Accept at edge E0. Memory samples at E1. rd_data is registered from mem_dout at E2, and rd_valid=1 for the cycle after E2.
  - Reads may be accepted back-to-back. A 2-deep valid pipeline tracks outstanding reads.
- Clear:
  - Issues one write per cycle: mem_we=1, mem_addr=counter, mem_din=latched colour.
  - Takes exactly 61440 cycles with busy=1.
  - Reads already in flight complete normally during CLEAR.
  - clear_start is ignored in CLEAR and in DONE.
- Out of range (y >= FB_H):
  - Plot: accepted, but mem_we is not asserted.
  - Read: accepted; rd_valid still pulses with rd_data=0.
  - x cannot be out of range because it is 8 bits.
- Reset mid-clear: aborts immediately with no clear_done. Pixels already cleared stay cleared.

Optional Feature:
- Macro: FB_DOUBLE_BUFFER_EN.
- When defined:
  - Adds inputs swap_req (pulse) and vblank, and output disp_page (1 bit, reset 0).
  - All plot, read and clear accesses use mem_addr[16] = ~disp_page, i.e. the back page.
  - swap_req sets a sticky pending flag. disp_page toggles on the first clock where vblank=1 and pending=1, and that same clock clears pending.
  - A swap is deferred while busy=1.
- When undefined: mem_addr[16]=0, and those ports do not exist.

Decomposition:
- Package fb_pkg holds:
  - constants FB_W, FB_H, PIX_W, ADDR_W, and FB_PIXELS=FB_H*256;
  - typedefs pixel_t, coord_t (8 bits) and fb_addr_t;
  - enum sched_state_t {IDLE, CLEAR, DONE};
  - the address-pack function.
- One sub-module, fb_clear_seq: the counter plus terminal-count flag, with inputs start/enable and outputs addr/last.

Test Plan:
- Single plot: x=5, y=3, pix=3'b101 -> one cycle later mem_we=1, mem_addr=773, mem_din=5. Read of (5,3) after it -> rd_valid pulse with rd_data=5.
- Contention: wr_valid and rd_valid_in held high for 6 cycles -> grants alternate W,R,W,R,W,R, with W first after reset.
- Clear: clear_pix=2, clear_start pulse -> busy high for exactly 61440 cycles, addresses 0..61439 in order, then clear_done for 1 cycle. rd_ready and wr_ready stay 0 throughout.
- Boundary: plot at y=240 -> wr_ready=1, mem_we stays 0. Read at (255,239) -> addr 61439 returns the written value. Read at y=250 -> rd_data=0.
- Reset mid-clear: reset_n=0 at counter 1000 -> all outputs 0 and no clear_done. A new clear restarts at address 0.
- FB_DOUBLE_BUFFER_EN: swap_req, then vblank 20 cycles later -> disp_page toggles on that vblank. Plots then use mem_addr[16] = new ~disp_page.
